// File: rtl/game_pkg.sv
// Shared game definitions: state encoding and the wall depth scoring window.
// Imported by round_sequencer and game_logic_controller.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_COUNTDOWN = 3'd1,
        ST_PLAYING   = 3'd2,
        ST_ROUND_END = 3'd3,
        ST_GAME_OVER = 3'd4
    } game_state_t;

    localparam int GOAL_DEPTH_DEF       = 60;
    localparam int GOAL_DEPTH_DELTA_DEF = 10;
    localparam int MAX_WALL_DEPTH_DEF   = 75;

    // Inclusive window [goal-delta, goal+delta] in which a collision counts.
    function automatic logic depth_in_window(input logic [7:0] depth,
                                             input int goal, input int delta);
        return (int'(depth) >= goal - delta) && (int'(depth) <= goal + delta);
    endfunction

endpackage

// File: rtl/evt_counter_dynamic.sv
// Loadable event down-counter.
//   clk_in/rst_in : clock, synchronous active-high reset (count -> 0)
//   load_in       : load load_val_in (wins over evt_in)
//   evt_in        : decrement by one, stopping at zero
//   count_out     : registered count
module evt_counter_dynamic #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             load_in,
    input  logic [WIDTH-1:0] load_val_in,
    input  logic             evt_in,
    output logic [WIDTH-1:0] count_out
);

    logic [WIDTH-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (load_in)
            count_d = load_val_in;
        else if (evt_in && count_q != '0)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count_out = count_q;

endmodule

// File: rtl/round_sequencer.sv
// Game round sequencer: start/countdown/play/round-end/game-over FSM that
// tracks lives, score, rounds, wall selection and wall speed.
//   clk_in, rst_in           : clock, synchronous active-high reset
//   start_in                 : debounced start level (rising edge acts)
//   new_frame_in             : one-cycle end-of-frame pulse
//   collision_in             : person-on-wall pixel collision
//   wall_depth_in            : current wall depth
//   wall_run_out             : wall tick counter enable (PLAYING only)
//   wall_depth_rst_out       : one-cycle clear of depth/tick counters
//   wall_tick_frequency_out  : frames per wall tick
//   wall_idx_out             : wall bit mask index
//   round_out, score_out     : rounds completed, score
//   lives_out, countdown_out : lives left, countdown frames left
//   game_state_out           : encoded game_state_t
module round_sequencer
    import game_pkg::*;
#(
    parameter int MAX_FRAMES_PER_WALL_TICK = 15,
    parameter int MIN_FRAMES_PER_WALL_TICK = 2,
    parameter int NUM_WALLS                = 10,
    parameter int COUNTDOWN_FRAMES         = 180,
    parameter int START_LIVES              = 3,
    parameter int GOAL_DEPTH               = GOAL_DEPTH_DEF,
    parameter int GOAL_DEPTH_DELTA         = GOAL_DEPTH_DELTA_DEF,
    parameter int MAX_WALL_DEPTH           = MAX_WALL_DEPTH_DEF,
    parameter int SPEEDUP_ROUNDS           = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic        new_frame_in,
    input  logic        collision_in,
    input  logic [7:0]  wall_depth_in,
    output logic        wall_run_out,
    output logic        wall_depth_rst_out,
    output logic [3:0]  wall_tick_frequency_out,
    output logic [3:0]  wall_idx_out,
    output logic [7:0]  round_out,
    output logic [15:0] score_out,
    output logic [1:0]  lives_out,
    output logic [7:0]  countdown_out,
    output logic [2:0]  game_state_out
);

    game_state_t state_d, state_q;
    logic        start_d, start_q;
    logic        hit_d, hit_q;
    logic        depth_rst_d, depth_rst_q;
    logic [1:0]  lives_d, lives_q;
    logic [15:0] score_d, score_q;
    logic [7:0]  round_d, round_q;
    logic [3:0]  idx_d, idx_q;
    logic [3:0]  freq_d, freq_q;
    logic        enter_cd;
    logic        start_edge;
    logic [7:0]  round_next;
    logic [16:0] score_sum;
    logic [7:0]  countdown;

    assign start_edge = start_in && !start_q;
    assign round_next = (round_q == 8'hFF) ? 8'hFF : round_q + 8'd1;
    assign score_sum  = {1'b0, score_q} + {9'd0, round_q} + 17'd1;

    always_comb begin
        state_d     = state_q;
        start_d     = start_in;
        hit_d       = hit_q;
        depth_rst_d = 1'b0;
        lives_d     = lives_q;
        score_d     = score_q;
        round_d     = round_q;
        idx_d       = idx_q;
        freq_d      = freq_q;
        enter_cd    = 1'b0;

        case (state_q)
            ST_IDLE, ST_GAME_OVER: begin
                if (start_edge) begin
                    lives_d  = 2'(START_LIVES);
                    score_d  = '0;
                    round_d  = '0;
                    idx_d    = '0;
                    freq_d   = 4'(MAX_FRAMES_PER_WALL_TICK);
                    enter_cd = 1'b1;
                end
            end
            ST_COUNTDOWN: begin
                // The counter reaches 0 on this same frame pulse.
                if (new_frame_in && countdown == 8'd1)
                    state_d = ST_PLAYING;
            end
            ST_PLAYING: begin
                if (collision_in &&
                    depth_in_window(wall_depth_in, GOAL_DEPTH, GOAL_DEPTH_DELTA))
                    hit_d = 1'b1;
                if (new_frame_in && wall_depth_in == 8'(MAX_WALL_DEPTH - 1))
                    state_d = ST_ROUND_END;
            end
            ST_ROUND_END: begin
                if (hit_q) begin
                    if (lives_q <= 2'd1) begin
                        lives_d = '0;
                        state_d = ST_GAME_OVER;
                    end else begin
                        lives_d  = lives_q - 2'd1;
                        enter_cd = 1'b1;
                    end
                end else begin
                    score_d  = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                    round_d  = round_next;
                    idx_d    = (idx_q == 4'(NUM_WALLS - 1)) ? 4'd0 : idx_q + 4'd1;
                    if ((int'(round_next) % SPEEDUP_ROUNDS) == 0 &&
                        freq_q > 4'(MIN_FRAMES_PER_WALL_TICK))
                        freq_d = freq_q - 4'd1;
                    enter_cd = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Common effects of every COUNTDOWN entry.
        if (enter_cd) begin
            state_d     = ST_COUNTDOWN;
            depth_rst_d = 1'b1;
            hit_d       = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q     <= ST_IDLE;
            start_q     <= 1'b0;
            hit_q       <= 1'b0;
            depth_rst_q <= 1'b0;
            lives_q     <= '0;
            score_q     <= '0;
            round_q     <= '0;
            idx_q       <= '0;
            freq_q      <= 4'(MAX_FRAMES_PER_WALL_TICK);
        end else begin
            state_q     <= state_d;
            start_q     <= start_d;
            hit_q       <= hit_d;
            depth_rst_q <= depth_rst_d;
            lives_q     <= lives_d;
            score_q     <= score_d;
            round_q     <= round_d;
            idx_q       <= idx_d;
            freq_q      <= freq_d;
        end
    end

    evt_counter_dynamic #(.WIDTH(8)) u_countdown (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .load_in     (enter_cd),
        .load_val_in (8'(COUNTDOWN_FRAMES)),
        .evt_in      (new_frame_in && state_q == ST_COUNTDOWN),
        .count_out   (countdown)
    );

    assign wall_run_out            = (state_q == ST_PLAYING);
    assign wall_depth_rst_out      = depth_rst_q;
    assign wall_tick_frequency_out = freq_q;
    assign wall_idx_out            = idx_q;
    assign round_out               = round_q;
    assign score_out               = score_q;
    assign lives_out               = lives_q;
    assign countdown_out           = countdown;
    assign game_state_out          = state_q;

endmodule

// File: tb/tb_round_sequencer.sv
// Scoreboard bench for round_sequencer: the stimulus thread plays randomized
// rounds and pushes the expected game status for every COUNTDOWN/GAME_OVER
// entry; a negedge monitor pops and compares when those entries occur.
module tb_round_sequencer;

    logic        clk_in = 1'b0;
    logic        rst_in, start_in, new_frame_in, collision_in;
    logic [7:0]  wall_depth_in;
    logic        wall_run_out, wall_depth_rst_out;
    logic [3:0]  wall_tick_frequency_out, wall_idx_out;
    logic [7:0]  round_out;
    logic [15:0] score_out;
    logic [1:0]  lives_out;
    logic [7:0]  countdown_out;
    logic [2:0]  game_state_out;

    always #5 clk_in = ~clk_in;

    round_sequencer dut (
        .clk_in                  (clk_in),
        .rst_in                  (rst_in),
        .start_in                (start_in),
        .new_frame_in            (new_frame_in),
        .collision_in            (collision_in),
        .wall_depth_in           (wall_depth_in),
        .wall_run_out            (wall_run_out),
        .wall_depth_rst_out      (wall_depth_rst_out),
        .wall_tick_frequency_out (wall_tick_frequency_out),
        .wall_idx_out            (wall_idx_out),
        .round_out               (round_out),
        .score_out               (score_out),
        .lives_out               (lives_out),
        .countdown_out           (countdown_out),
        .game_state_out          (game_state_out)
    );

    typedef struct {
        int st, lives, score, round, idx, freq;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Reference game status
    int m_lives, m_score, m_round, m_idx, m_freq;

    task automatic check(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic push(input int st);
        exp_t e;
        e.st = st; e.lives = m_lives; e.score = m_score;
        e.round = m_round; e.idx = m_idx; e.freq = m_freq;
        exp_q.push_back(e);
    endtask

    task automatic model_start();
        m_lives = 3; m_score = 0; m_round = 0; m_idx = 0; m_freq = 15;
        push(1);
    endtask

    task automatic model_round(input int cd);
        int old_round;
        if (cd >= 50 && cd <= 70) begin
            m_lives = m_lives - 1;
            push(m_lives == 0 ? 4 : 1);
        end else begin
            old_round = m_round;
            m_round   = (m_round < 255) ? m_round + 1 : 255;
            m_score   = m_score + old_round + 1;
            if (m_score > 65535) m_score = 65535;
            m_idx     = (m_idx + 1) % 10;
            if (m_round % 2 == 0 && m_freq > 2) m_freq = m_freq - 1;
            push(1);
        end
    endtask

    // Monitor
    int prev_st = 0;
    int re_cnt  = 0;
    always @(negedge clk_in) begin
        bit   entered_cd;
        exp_t e;
        entered_cd = (game_state_out == 3'd1) && (prev_st != 1);
        if (wall_depth_rst_out || entered_cd)
            check("depth_rst_pulse", int'(wall_depth_rst_out), int'(entered_cd));
        if (entered_cd)
            check("countdown_load", int'(countdown_out), 180);
        if (int'(game_state_out) != prev_st &&
            (game_state_out == 3'd1 || game_state_out == 3'd4)) begin
            if (exp_q.size() == 0) begin
                tests++; fails++;
                $display("FAIL unexpected_entry: got state %0d, expected no entry",
                         game_state_out);
            end else begin
                e = exp_q.pop_front();
                check("sb_state", int'(game_state_out), e.st);
                check("sb_lives", int'(lives_out), e.lives);
                check("sb_score", int'(score_out), e.score);
                check("sb_round", int'(round_out), e.round);
                check("sb_idx",   int'(wall_idx_out), e.idx);
                check("sb_freq",  int'(wall_tick_frequency_out), e.freq);
            end
        end
        if (game_state_out == 3'd3) re_cnt++;
        else if (prev_st == 3) begin
            check("round_end_len", re_cnt, 1);
            re_cnt = 0;
        end
        prev_st = int'(game_state_out);
    end

    task automatic tick();
        @(posedge clk_in); #1;
    endtask

    task automatic check_reset_vals();
        check("rst_state",   int'(game_state_out), 0);
        check("rst_run",     int'(wall_run_out), 0);
        check("rst_dpulse",  int'(wall_depth_rst_out), 0);
        check("rst_freq",    int'(wall_tick_frequency_out), 15);
        check("rst_idx",     int'(wall_idx_out), 0);
        check("rst_round",   int'(round_out), 0);
        check("rst_score",   int'(score_out), 0);
        check("rst_cd",      int'(countdown_out), 0);
        check("rst_lives",   int'(lives_out), 0);
    endtask

    task automatic wait_state(input int target, input int budget);
        for (int i = 0; i < budget && int'(game_state_out) != target; i++) tick();
        check("wait_state", int'(game_state_out), target);
    endtask

    // 180 frame pulses; optional start pokes which must be ignored.
    task automatic run_countdown(input bit poke);
        for (int i = 0; i < 180; i++) begin
            if (poke && i == 50) start_in = 1'b1;
            if (poke && i == 60) start_in = 1'b0;
            if (i == 179) begin
                check("cd_last_state", int'(game_state_out), 1);
                check("cd_last_val", int'(countdown_out), 1);
            end
            new_frame_in = 1'b1; tick();
            new_frame_in = 1'b0; tick();
        end
        check("play_state", int'(game_state_out), 2);
        check("play_run", int'(wall_run_out), 1);
        check("play_cd", int'(countdown_out), 0);
    endtask

    // Sweep depth 0..74, colliding only at depth cd (-1 for none).
    task automatic play_round(input int cd);
        model_round(cd);
        for (int d = 0; d < 75; d++) begin
            wall_depth_in = 8'(d);
            collision_in  = (d == cd);
            new_frame_in  = 1'b0; tick();
            new_frame_in  = 1'b1; tick();
        end
        new_frame_in = 1'b0; collision_in = 1'b0; wall_depth_in = 8'd0;
        check("round_end_state", int'(game_state_out), 3);
    endtask

    function automatic int clean_depth();
        int r;
        r = int'($urandom_range(0, 3));
        if (r == 0) return -1;
        if (r == 1) return int'($urandom_range(71, 74));
        return int'($urandom_range(0, 49));
    endfunction

    initial begin
        rst_in = 1'b1; start_in = 1'b0; new_frame_in = 1'b0;
        collision_in = 1'b0; wall_depth_in = 8'd0;
        repeat (3) tick();
        check_reset_vals();
        rst_in = 1'b0; tick(); tick();
        check_reset_vals();

        // Game start
        model_start();
        start_in = 1'b1; tick(); tick();
        check("start_lives", int'(lives_out), 3);
        start_in = 1'b0; tick();
        run_countdown(1'b1);

        play_round(-1);      wait_state(1, 4); run_countdown(1'b0);
        play_round(50);      wait_state(1, 4); run_countdown(1'b0);
        play_round(70);      wait_state(1, 4); run_countdown(1'b0);
        play_round(49);      wait_state(1, 4); run_countdown(1'b0);
        play_round(71);      wait_state(1, 4); run_countdown(1'b0);

        while (m_round < 30) begin
            play_round(clean_depth()); wait_state(1, 4); run_countdown(1'b0);
        end
        check("r30_score", int'(score_out), 465);
        check("r30_freq",  int'(wall_tick_frequency_out), 2);
        check("r30_idx",   int'(wall_idx_out), 0);
        check("r30_round", int'(round_out), 30);
        for (int k = 0; k < 3; k++) begin
            play_round(clean_depth()); wait_state(1, 4); run_countdown(1'b0);
        end
        check("freq_floor", int'(wall_tick_frequency_out), 2);

        // Last life: start held high across the hit so no new edge occurs
        start_in = 1'b1;
        play_round(int'($urandom_range(50, 70)));
        wait_state(4, 4);
        repeat (10) tick();
        check("go_hold_state", int'(game_state_out), 4);
        check("go_hold_run",   int'(wall_run_out), 0);
        check("go_hold_lives", int'(lives_out), 0);
        check("go_hold_score", int'(score_out), m_score);
        check("go_hold_round", int'(round_out), m_round);

        // Re-armed start restarts the game
        start_in = 1'b0; tick();
        model_start();
        start_in = 1'b1; tick(); tick();
        start_in = 1'b0;
        run_countdown(1'b0);

        // Reset in the middle of a round
        for (int d = 0; d < 20; d++) begin
            wall_depth_in = 8'(d);
            new_frame_in = 1'b0; tick();
            new_frame_in = 1'b1; tick();
        end
        new_frame_in = 1'b0;
        rst_in = 1'b1; tick();
        check_reset_vals();
        rst_in = 1'b0; tick();
        check("sb_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
